shift_sequencer: RTL and testbench

- Multi-cycle controller placed directly upstream of the combinational single-step `shifter` in the 8-bit ALU.
- Accepts an operand, a shift op and a shift amount through a start/ready handshake.
- Drives the shifter once per clock, feeds the shifter output back into its working register, and reports the final result with carry and zero flags and a one-cycle done pulse.
- The shifter stays a separate instance; this block connects to it only through the `sh_*` ports.

---
 rtl/shift_sequencer.sv | 124 ++++++++++++
 tb/tb_shift_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle controller for the single-step shifter: iterates the shift amt times,
// feeding sh_Out back into the working register, then reports result/carry/zero.
module shift_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic [WIDTH-1:0] sh_A,
  output logic [1:0]       sh_Sel,
  input  logic [WIDTH-1:0] sh_Out
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [AMT_W-1:0] CntOne = AMT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [1:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             bit_out;

  // op[0] set means a rightward move, so the leaving bit is the LSB.
  assign bit_out = op_q[0] ? work_q[0] : work_q[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          work_d = A;
          op_d   = op;
          cnt_d  = amt;
          acc_d  = 1'b0;
          if (amt == '0) begin
            state_d  = StDone;
            result_d = A;
            carry_d  = 1'b0;
            zero_d   = (A == '0);
          end else begin
            state_d = StShift;
          end
        end
      end

      StShift: begin
        acc_d  = bit_out;
        work_d = sh_Out;
        cnt_d  = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d  = StDone;
          result_d = sh_Out;
          carry_d  = bit_out;
          zero_d   = (sh_Out == '0);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      work_q   <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign ready  = (state_q == StIdle);
  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign sh_A   = work_q;
  assign sh_Sel = op_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural shifter stand-in plus an arithmetic reference model.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] A;
  logic [1:0] op;
  logic [2:0] amt;
  logic       ready, busy, done, carry, zero;
  logic [7:0] result, sh_A, sh_Out;
  logic [1:0] sh_Sel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .op(op), .amt(amt),
    .ready(ready), .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero),
    .sh_A(sh_A), .sh_Sel(sh_Sel), .sh_Out(sh_Out)
  );

  // Stand-in for the external single-step shifter.
  always_comb begin
    case (sh_Sel)
      2'b00:   sh_Out = {sh_A[6:0], 1'b0};
      2'b01:   sh_Out = {1'b0, sh_A[7:1]};
      2'b10:   sh_Out = {sh_A[6:0], sh_A[7]};
      default: sh_Out = {sh_A[0], sh_A[7:1]};
    endcase
  end

  // Whole-operation model from shift/rotate arithmetic, not step by step.
  function automatic void ref_model(input logic [7:0] a, input logic [1:0] o, input int n,
                                    output logic [7:0] r, output logic c);
    logic [15:0] w;
    int unsigned av;
    av = a;
    r = a;
    c = 1'b0;
    if (n != 0) begin
      case (o)
        2'b00: begin r = 8'((av << n) & 255); c = 1'((av >> (8 - n)) & 1); end
        2'b01: begin r = 8'(av >> n);         c = 1'((av >> (n - 1)) & 1); end
        2'b10: begin w = {a, a} << n; r = w[15:8]; c = r[0]; end
        default: begin w = {a, a} >> n; r = w[7:0]; c = r[7]; end
      endcase
    end
  endfunction

  // Issues one request from IDLE and collects observations up to the done pulse.
  task automatic do_req(input logic [7:0] a_v, input logic [1:0] op_v, input logic [2:0] amt_v,
                        output int lat, output int busy_n, output bit sel_ok,
                        output logic [7:0] r, output logic c, output logic z,
                        output logic done_next, output bit timed_out);
    A = a_v; op = op_v; amt = amt_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 8'($urandom); op = 2'($urandom); amt = 3'($urandom);
    lat = 1; busy_n = 0; sel_ok = 1; timed_out = 0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) busy_n++;
      if (sh_Sel !== op_v) sel_ok = 0;
      if (lat >= 40) begin timed_out = 1; break; end
      @(posedge clk); #1;
      lat++;
    end
    if (sh_Sel !== op_v) sel_ok = 0;
    r = result; c = carry; z = zero;
    @(posedge clk); #1;
    done_next = done;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; A = 8'hFF; op = 2'b11; amt = 3'd7;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctrl: got ready/busy/done=%b want 100", {ready, busy, done});
    end
    checks++;
    if ({result, carry, zero, sh_A, sh_Sel} !== 20'h0) begin
      failures++;
      $display("FAIL reset_regs: got result=%h carry=%b zero=%b sh_A=%h sh_Sel=%b want all 0",
               result, carry, zero, sh_A, sh_Sel);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [7:0] ta [5] = '{8'h0A, 8'hF6, 8'h81, 8'h0A, 8'h80};
    logic [1:0] to [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic [2:0] tn [5] = '{3'd3, 3'd4, 3'd1, 3'd0, 3'd1};
    logic [7:0] tr [5] = '{8'h50, 8'h0F, 8'h03, 8'h0A, 8'h00};
    logic       tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       tz [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat, bn; bit sok, to_; logic [7:0] r; logic c, z, dn;
    for (int i = 0; i < 5; i++) begin
      do_req(ta[i], to[i], tn[i], lat, bn, sok, r, c, z, dn, to_);
      checks++;
      if (to_ || lat != int'(tn[i]) + 1 || bn != int'(tn[i])) begin
        failures++;
        $display("FAIL dir%0d_timing: got latency=%0d busy=%0d timeout=%0b want latency=%0d busy=%0d",
                 i, lat, bn, to_, tn[i] + 1, tn[i]);
      end
      checks++;
      if ({r, c, z} !== {tr[i], tc[i], tz[i]}) begin
        failures++;
        $display("FAIL dir%0d_result: got r=%h c=%b z=%b want r=%h c=%b z=%b",
                 i, r, c, z, tr[i], tc[i], tz[i]);
      end
      checks++;
      if (dn !== 1'b0 || ready !== 1'b1) begin
        failures++;
        $display("FAIL dir%0d_pulse: got done_next=%b ready=%b want 0 1", i, dn, ready);
      end
    end
  endtask

  task automatic test_sweep;
    int lat, bn; bit sok, to_; logic [7:0] r, er; logic c, z, dn, ec;
    for (int o = 0; o < 4; o++) begin
      for (int n = 0; n < 8; n++) begin
        ref_model(8'h5A, 2'(o), n, er, ec);
        do_req(8'h5A, 2'(o), 3'(n), lat, bn, sok, r, c, z, dn, to_);
        checks++;
        if (to_ || !sok || {r, c, z} !== {er, ec, (er == 8'h00)} || lat != n + 1) begin
          failures++;
          $display("FAIL sweep op=%0d amt=%0d: got r=%h c=%b z=%b lat=%0d sel_ok=%0b want r=%h c=%b lat=%0d",
                   o, n, r, c, z, lat, sok, er, ec, n + 1);
        end
      end
    end
  endtask

  task automatic test_random;
    int lat, bn; bit sok, to_; logic [7:0] r, er, av; logic c, z, dn, ec; logic [1:0] ov;
    logic [2:0] nv;
    for (int i = 0; i < 40; i++) begin
      av = 8'($urandom); ov = 2'($urandom); nv = 3'($urandom);
      ref_model(av, ov, int'(nv), er, ec);
      do_req(av, ov, nv, lat, bn, sok, r, c, z, dn, to_);
      checks++;
      if (to_ || !sok || {r, c, z} !== {er, ec, (er == 8'h00)} || bn != int'(nv) || dn !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d A=%h op=%0d amt=%0d: got r=%h c=%b z=%b busy=%0d want r=%h c=%b busy=%0d",
                 i, av, ov, nv, r, c, z, bn, er, ec, nv);
      end
    end
  endtask

  task automatic test_back_to_back;
    int dcnt = 0;
    logic [7:0] r1 = 8'h00, r2 = 8'h00; logic c1 = 1'b0, c2 = 1'b0;
    A = 8'h0A; op = 2'b00; amt = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    A = 8'hFF; op = 2'b01; amt = 3'd2;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (done === 1'b1) begin
        dcnt++;
        if (dcnt == 1) begin r1 = result; c1 = carry; end
        else begin r2 = result; c2 = carry; end
      end
      if (dcnt == 1 && busy === 1'b1) start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if ({r1, c1} !== {8'h50, 1'b0}) begin
      failures++;
      $display("FAIL b2b_first: got r=%h c=%b want r=50 c=0", r1, c1);
    end
    checks++;
    if ({r2, c2} !== {8'h3F, 1'b1}) begin
      failures++;
      $display("FAIL b2b_second: got r=%h c=%b want r=3f c=1", r2, c2);
    end
    checks++;
    if (dcnt != 2) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d want 2", dcnt);
    end
  endtask

  task automatic test_mid_reset;
    int dcnt = 0;
    A = 8'h33; op = 2'b10; amt = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({ready, busy, done} !== 3'b100 || {result, carry, zero, sh_A} !== 18'h0) begin
      failures++;
      $display("FAIL mid_reset: got rbd=%b result=%h carry=%b zero=%b sh_A=%h want 100 and zeros",
               {ready, busy, done}, result, carry, zero, sh_A);
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (done === 1'b1) dcnt++;
      @(posedge clk); #1;
    end
    // Reset and start on the same edge: the request must be dropped.
    A = 8'h01; op = 2'b00; amt = 3'd0; start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (done === 1'b1 || busy === 1'b1) dcnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (dcnt != 0 || result !== 8'h00) begin
      failures++;
      $display("FAIL reset_drop: got stray activity=%0d result=%h want 0 00", dcnt, result);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sweep();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
